// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - paced ADC convert/capture/average/decide sequencer
//
// Paces conversions of the external 12-bit ADC from a period counter, waits for
// each conversion with a timeout, averages 2^AVG_LOG2 results and decides
// whether the averaged level is below THRESH. The result drives ADC_comp.
// Optional macro ADC_HYST_EN adds a hysteresis band of +/-HYST around THRESH.
//
// Ports:
//   clk          in   clock, rising edge
//   nrst         in   asynchronous active-low reset
//   swiptAlive   in   enable; low returns the block to the cleared idle state
//   adc_data     in   conversion result, valid while adc_done=1
//   adc_done     in   one-cycle end-of-conversion strobe
//   adc_start    out  one-cycle start-of-conversion pulse
//   sample       out  latest averaged sample
//   sample_valid out  one-cycle pulse when sample/ADC_comp update
//   ADC_comp     out  1 = averaged level below threshold
//   timeout_err  out  one-cycle pulse when a conversion never completed

module adc_sample_sequencer #(
    parameter int          PERIOD   = 400,
    parameter int          AVG_LOG2 = 2,
    parameter int          TIMEOUT  = 63,
    parameter logic [11:0] THRESH   = 12'h800,
    parameter logic [11:0] HYST     = 12'h040
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic [11:0] adc_data,
    input  logic        adc_done,
    output logic        adc_start,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        ADC_comp,
    output logic        timeout_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_DONE,
        DECIDE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [8:0]         period_cnt;
    logic [7:0]         tmo_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [11:0]        avg;
    logic               tick;
    logic               done_ok;
    logic               last_sample;
    logic               tmo_exp;
    logic               comp_nxt;

    assign tick        = (state != IDLE) && (period_cnt == 9'd0);
    assign done_ok     = (state == WAIT_DONE) && adc_done;
    assign cnt_inc     = cnt + CNT_W'(1);
    assign last_sample = done_ok && (cnt_inc == CNT_W'(NSAMP));
    // The counter is loaded on entry to START and keeps counting down, so the
    // value 1 here means it reaches 0 on this edge. A done in the same cycle
    // takes priority.
    assign tmo_exp     = (state == WAIT_DONE) && !adc_done && (tmo_cnt <= 8'd1);
    assign avg         = 12'(acc >> AVG_LOG2);

`ifdef ADC_HYST_EN
    localparam logic [11:0] BAND_LO = (THRESH >= HYST) ? (THRESH - HYST) : 12'h000;
    localparam logic [12:0] HI_RAW  = {1'b0, THRESH} + {1'b0, HYST};
    localparam logic [11:0] BAND_HI = HI_RAW[12] ? 12'hFFF : HI_RAW[11:0];

    always_comb begin
        comp_nxt = ADC_comp;
        if (avg < BAND_LO) begin
            comp_nxt = 1'b1;
        end else if (avg >= BAND_HI) begin
            comp_nxt = 1'b0;
        end
    end
`else
    // HYST only matters when the band is enabled.
    localparam logic [11:0] unused_hyst = HYST;

    always_comb begin
        comp_nxt = (avg < THRESH);
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = WAIT_TICK;
            WAIT_TICK: if (tick) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (done_ok) begin
                    state_nxt = last_sample ? DECIDE : WAIT_TICK;
                end else if (tmo_exp) begin
                    state_nxt = WAIT_TICK;
                end
            end
            DECIDE:    state_nxt = WAIT_TICK;
            default:   state_nxt = IDLE;
        endcase
        if (!swiptAlive) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Free-running pacing: ticks that arrive outside WAIT_TICK are simply lost.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_cnt <= 9'(PERIOD - 1);
        end else if (!swiptAlive || state == IDLE) begin
            period_cnt <= 9'(PERIOD - 1);
        end else if (period_cnt == 9'd0) begin
            period_cnt <= 9'(PERIOD - 1);
        end else begin
            period_cnt <= period_cnt - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            adc_start    <= 1'b0;
            sample       <= 12'h000;
            sample_valid <= 1'b0;
            ADC_comp     <= 1'b0;
            timeout_err  <= 1'b0;
            tmo_cnt      <= 8'd0;
            acc          <= '0;
            cnt          <= '0;
        end else if (!swiptAlive) begin
            adc_start    <= 1'b0;
            sample       <= 12'h000;
            sample_valid <= 1'b0;
            ADC_comp     <= 1'b0;
            timeout_err  <= 1'b0;
            tmo_cnt      <= 8'd0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            adc_start    <= (state_nxt == START);
            sample_valid <= (state == DECIDE);
            timeout_err  <= tmo_exp;

            if (state_nxt == START) begin
                tmo_cnt <= 8'(TIMEOUT);
            end else if (tmo_cnt != 8'd0) begin
                tmo_cnt <= tmo_cnt - 8'd1;
            end

            if (done_ok) begin
                acc <= acc + ACC_W'(adc_data);
                cnt <= cnt_inc;
            end else if (tmo_exp) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == DECIDE) begin
                sample   <= avg;
                ADC_comp <= comp_nxt;
                acc      <= '0;
                cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - scoreboard bench for adc_sample_sequencer

module tb_adc_sample_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic [11:0] adc_data;
    logic        adc_done;
    logic        adc_start;
    logic [11:0] sample;
    logic        sample_valid;
    logic        ADC_comp;
    logic        timeout_err;

    adc_sample_sequencer dut (
        .clk          (clk),
        .nrst         (nrst),
        .swiptAlive   (swiptAlive),
        .adc_data     (adc_data),
        .adc_done     (adc_done),
        .adc_start    (adc_start),
        .sample       (sample),
        .sample_valid (sample_valid),
        .ADC_comp     (ADC_comp),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] s;
        logic        c;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tmo_seen = 0;
    logic model_comp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic model_next(input logic [11:0] a, input logic prev);
        logic r;
        r = prev;
`ifdef ADC_HYST_EN
        begin
            int lo;
            int hi;
            lo = 'h800 - 'h40;
            hi = 'h800 + 'h40;
            if (lo < 0) lo = 0;
            if (hi > 'hFFF) hi = 'hFFF;
            if (int'(a) < lo) r = 1'b1;
            else if (int'(a) >= hi) r = 1'b0;
        end
`else
        r = (a < 12'h800);
`endif
        return r;
    endfunction

    // Scoreboard side: every sample_valid must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sample_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sample", 32'(sample), 32'(e.s));
                check("adc_comp", 32'(ADC_comp), 32'(e.c));
                check("valid_cycle", 32'(cyc), 32'(e.t));
            end
        end
        if (timeout_err) tmo_seen++;
    end

    task automatic wait_start(output int ts);
        ts = -1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (adc_start) begin
                ts = cyc;
                break;
            end
        end
        if (ts < 0) check("start_timeout", 32'd0, 32'd1);
    endtask

    // dly < 0 suppresses adc_done; otherwise done is presented dly cycles after start.
    task automatic convert(input logic [11:0] d, input int dly, input bit push,
                           input logic [11:0] es, input logic ec, output int ts);
        wait_start(ts);
        if (dly >= 0) begin
            repeat (dly) @(posedge clk);
            #1;
            adc_data = d;
            adc_done = 1'b1;
            if (push) sb.push_back('{es, ec, cyc + 2});
            @(posedge clk);
            #1;
            adc_done = 1'b0;
            adc_data = 12'h000;
        end
    endtask

    task automatic run_group(input logic [11:0] a0, input logic [11:0] a1,
                             input logic [11:0] a2, input logic [11:0] a3,
                             input int d1, output int ts0);
        logic [11:0] v[4];
        logic [11:0] avg;
        logic        c;
        int          sum;
        int          ts;
        v   = '{a0, a1, a2, a3};
        sum = int'(a0) + int'(a1) + int'(a2) + int'(a3);
        avg = 12'(sum / 4);
        c   = model_next(avg, model_comp);
        model_comp = c;
        ts0 = -1;
        for (int i = 0; i < 4; i++) begin
            convert(v[i], (i == 1) ? d1 : 5, (i == 3), avg, c, ts);
            if (i == 0) ts0 = ts;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          r;
        int          ts;
        int          ts2;
        int          k;
        int          tmo_t;
        logic [11:0] th[7];

        nrst       = 1'b0;
        swiptAlive = 1'b1;
        adc_done   = 1'b0;
        adc_data   = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 32'(adc_start), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_comp", 32'(ADC_comp), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        r    = cyc;
        nrst = 1'b1;

        // Averaging and pacing: 0x700,0x700,0x900,0x900 -> 0x800
        model_comp = model_next(12'h800, model_comp);
        convert(12'h700, 5, 1'b0, 12'h0, 1'b0, ts);
        check("first_start", 32'(ts), 32'(r + 401));
        convert(12'h700, 5, 1'b0, 12'h0, 1'b0, ts2);
        check("period", 32'(ts2 - ts), 32'd400);
        convert(12'h900, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h900, 5, 1'b1, 12'h800, model_comp, ts);

        // Threshold decisions (hysteresis sequence inside)
        th = '{12'h7FF, 12'h800, 12'h7C0, 12'h7BF, 12'h83F, 12'h840, 12'h7FF};
        for (int i = 0; i < 7; i++) begin
            run_group(th[i], th[i], th[i], th[i], 5, ts);
        end
        // Truncating shift and full-scale accumulation
        run_group(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 5, ts);
        run_group(12'h003, 12'h000, 12'h000, 12'h000, 5, ts);

        // Timeout mid-group clears the partial accumulation
        convert(12'hFFF, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'hFFF, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h000, -1, 1'b0, 12'h0, 1'b0, ts);
        tmo_t = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (timeout_err) begin
                tmo_t = cyc;
                break;
            end
        end
        check("tmo_delay", 32'(tmo_t - ts), 32'd63);
        @(posedge clk);
        #1;
        check("tmo_pulse_width", 32'(timeout_err), 32'd0);
        run_group(12'h100, 12'h100, 12'h100, 12'h100, 5, ts);

        // Done in the expiry cycle wins
        run_group(12'h200, 12'h200, 12'h200, 12'h200, 62, ts);
        check("tmo_count_corner", 32'(tmo_seen), 32'd1);

        // Disable in WAIT_DONE after two samples
        convert(12'h500, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h500, 5, 1'b0, 12'h0, 1'b0, ts);
        wait_start(ts);
        @(posedge clk);
        #1;
        swiptAlive = 1'b0;
        @(posedge clk);
        #1;
        check("dis_sample", 32'(sample), 32'd0);
        check("dis_comp", 32'(ADC_comp), 32'd0);
        check("dis_valid", 32'(sample_valid), 32'd0);
        check("dis_start", 32'(adc_start), 32'd0);
        adc_data = 12'hFFF;
        adc_done = 1'b1;
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        adc_data = 12'h000;
        repeat (5) @(posedge clk);
        #1;
        model_comp = 1'b0;
        k          = cyc;
        swiptAlive = 1'b1;
        run_group(12'h300, 12'h300, 12'h300, 12'h300, 5, ts);
        check("reenable_start", 32'(ts), 32'(k + 401));

        // Asynchronous reset while in DECIDE
        convert(12'h100, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h100, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h100, 5, 1'b0, 12'h0, 1'b0, ts);
        convert(12'h100, 5, 1'b0, 12'h0, 1'b0, ts);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_sample", 32'(sample), 32'd0);
        check("arst_comp", 32'(ADC_comp), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        model_comp = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("arst_hold_sample", 32'(sample), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("tmo_count", 32'(tmo_seen), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Sequences the external 12-bit ADC for the SWIPT receive path. It paces conversions from a programmable period counter, handshakes each conversion, and averages 2^AVG_LOG2 samples. It then makes a threshold decision, with optional hysteresis, that drives `ADC_comp` to the PLL front end. It replaces free-running sampling with a controlled convert/capture/decide sequence and flags conversions that never complete.

## Interface
- `PERIOD`, 400: clock cycles between conversion starts; legal range 2..511.
- `AVG_LOG2`, 2: log2 of the number of samples averaged per decision; legal range 0..4.
- `TIMEOUT`, 63: maximum number of cycles to wait for `adc_done` after `adc_start`; legal range 1..255.
- `THRESH`, 12'h800: decision threshold.
- `HYST`, 12'h040: half-width of the hysteresis band; used only with `ADC_HYST_EN`.

- `clk`  in  1  single clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `swiptAlive`  in  1  enable; low synchronously forces the idle/cleared state.
- `adc_data`  in  12  conversion result; valid in the cycle `adc_done`=1.
- `adc_done`  in  1  one-cycle end-of-conversion strobe.
- `adc_start`  out  1  one-cycle start-of-conversion pulse.
- `sample`  out  12  latest averaged sample.
- `sample_valid`  out  1  one-cycle pulse when `sample`/`ADC_comp` update.
- `ADC_comp`  out  1  1 = averaged level below threshold.
- `timeout_err`  out  1  one-cycle pulse when a conversion times out.

## Operation
- Reset values (`nrst`=0, asynchronous): all outputs 0, state IDLE, period counter = PERIOD-1, accumulator = 0, sample count = 0.
- Period counter:
  - Runs in every state except IDLE, counting down to 0.
  - At 0 it emits an internal one-cycle `tick` and reloads PERIOD-1.
- FSM states:
  - IDLE: entered while `swiptAlive`=0. Goes to WAIT_TICK the cycle after `swiptAlive`=1.
  - WAIT_TICK: on `tick`, goes to START.
  - START: `adc_start`=1 for exactly one cycle; load the timeout counter with TIMEOUT; go to WAIT_DONE.
  - WAIT_DONE:
    - On `adc_done`: `acc += adc_data`, increment the sample count.
    - If the count now equals 2^AVG_LOG2, go to DECIDE; otherwise go to WAIT_TICK.
    - If the timeout counter reaches 0 first: pulse `timeout_err`, clear acc and count, go to WAIT_TICK.
  - DECIDE:
    - `sample` <= acc >> AVG_LOG2; update `ADC_comp`; pulse `sample_valid`.
    - Clear acc and count; go to WAIT_TICK.
- Arithmetic: the accumulator is 12+AVG_LOG2 bits wide and unsigned; it cannot overflow. The shift truncates (no rounding).
- `tick` arriving outside WAIT_TICK is dropped; there is no queueing and the period does not stretch.
- `adc_done` outside WAIT_DONE is ignored.
- `adc_done` in the same cycle the timeout counter hits 0: done wins and the sample is accepted.
- `swiptAlive`=0 in any state: the next state is IDLE with the same cleared values as reset, including `ADC_comp`=0. Any in-flight conversion is abandoned.

## Timing
- `adc_start` is asserted 1 cycle after the `tick` cycle.
- Decision latency: `sample_valid` is asserted 2 cycles after the accepting `adc_done` of the last sample (WAIT_DONE→DECIDE, then the registered output).
- `sample` and `ADC_comp` change only in the cycle `sample_valid`=1 and hold otherwise.
- With `swiptAlive` held high, the first `adc_start` occurs PERIOD+1 cycles after IDLE exit.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ADC_HYST_EN` defined:
  - `ADC_comp` → 1 when avg < THRESH-HYST.
  - `ADC_comp` → 0 when avg ≥ THRESH+HYST.
  - Otherwise `ADC_comp` holds its previous value.
  - Both band edges saturate at 0 and 12'hFFF.
- `ADC_HYST_EN` undefined: `ADC_comp` = (avg < THRESH). `HYST` is unused and no band logic is synthesized.

## Test plan
- Reset/enable: hold `nrst`=0, then release with `swiptAlive`=1 → all outputs 0; first `adc_start` at PERIOD+1=401 cycles after IDLE exit, then every 400 cycles.
- Averaging: model returns 0x700, 0x700, 0x900, 0x900, each `adc_done` 5 cycles after start → `sample`=0x800, `sample_valid` pulses once, 2 cycles after the 4th done.
- Threshold:
  - Without `ADC_HYST_EN`: avg 0x7FF → `ADC_comp`=1; avg 0x800 → 0.
  - With `ADC_HYST_EN`: the sequence of averages 0x7C0, 0x7BF, 0x83F, 0x840 gives `ADC_comp` hold(0), 1, 1, 0.
- Timeout: suppress `adc_done` → `timeout_err` pulses 63 cycles after `adc_start`, acc cleared; the next 4 good samples of 0x100 give `sample`=0x100.
  - Corner: `adc_done` in the timeout-expiry cycle → sample accepted, no `timeout_err`.
- Disable mid-operation: drop `swiptAlive` in WAIT_DONE after 2 samples → next cycle all outputs 0; a late `adc_done` is ignored. On re-enable, 4 fresh samples are needed before `sample_valid`.
- Async reset: assert `nrst` mid-cycle during DECIDE → outputs clear immediately, without waiting for a `clk` edge.
